// File: rtl/bitout_seq.sv
// Avalon-MM slave that shifts a programmed bit pattern out of one pin, LSB-first,
// then parks the pin at a programmable idle level and raises a sticky done flag.
// state | meaning
// IDLE  | pin = IDLE_LVL, waiting for START
// RUN   | pin = shadow pattern bit at idx, dwell counter running
module bitout_seq #(
  parameter int          PRESCALE_W     = 24,
  parameter int unsigned RESET_PRESCALE = 0
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic [1:0]  avs_s1_address,
  input  logic        avs_s1_read,
  output logic [31:0] avs_s1_readdata,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  output logic        ins_irq,
  output logic        coe_bit
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic                  idle_lvl_q, idle_lvl_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic [31:0]           pattern_q, pattern_d;
  logic [4:0]            len_m1_q, len_m1_d;
  logic [7:0]            repeat_q, repeat_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           sh_pattern_q, sh_pattern_d;
  logic [4:0]            sh_len_m1_q, sh_len_m1_d;
  logic [PRESCALE_W-1:0] sh_prescale_q, sh_prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]            pass_cnt_q, pass_cnt_d;
  logic [4:0]            idx_q, idx_d;
  logic                  bit_q, bit_d;

  logic wr_ctrl, start_req, stop_req;

  assign wr_ctrl   = avs_s1_write && (avs_s1_address == 2'd0);
  assign stop_req  = wr_ctrl && avs_s1_writedata[1];
  assign start_req = wr_ctrl && avs_s1_writedata[0] && !avs_s1_writedata[1];

  always_comb begin
    state_d       = state_q;
    idle_lvl_d    = idle_lvl_q;
    irq_en_d      = irq_en_q;
    done_d        = done_q;
    pattern_d     = pattern_q;
    len_m1_d      = len_m1_q;
    repeat_d      = repeat_q;
    prescale_d    = prescale_q;
    sh_pattern_d  = sh_pattern_q;
    sh_len_m1_d   = sh_len_m1_q;
    sh_prescale_d = sh_prescale_q;
    pre_cnt_d     = pre_cnt_q;
    pass_cnt_d    = pass_cnt_q;
    idx_d         = idx_q;

    if (wr_ctrl) begin
      idle_lvl_d = avs_s1_writedata[2];
      irq_en_d   = avs_s1_writedata[4];
      if (avs_s1_writedata[3]) done_d = 1'b0;
    end
    if (avs_s1_write && avs_s1_address == 2'd1) pattern_d = avs_s1_writedata;
    if (avs_s1_write && avs_s1_address == 2'd2) begin
      len_m1_d = avs_s1_writedata[4:0];
      repeat_d = avs_s1_writedata[15:8];
    end
    if (avs_s1_write && avs_s1_address == 2'd3) prescale_d = avs_s1_writedata[PRESCALE_W-1:0];

    if (stop_req) begin
      if (state_q == ST_RUN) begin
        state_d   = ST_IDLE;
        idx_d     = '0;
        pre_cnt_d = '0;
      end
    end else if (start_req) begin
      state_d       = ST_RUN;
      sh_pattern_d  = pattern_q;
      sh_len_m1_d   = len_m1_q;
      sh_prescale_d = prescale_q;
      pass_cnt_d    = repeat_q;
      pre_cnt_d     = '0;
      idx_d         = '0;
      done_d        = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (pre_cnt_q == sh_prescale_q) begin
        pre_cnt_d = '0;
        if (idx_q < sh_len_m1_q) begin
          idx_d = idx_q + 5'd1;
        end else begin
          idx_d = '0;
          // A zero pass count only ever occurs for an infinite sequence.
          if (pass_cnt_q != 8'd0) begin
            pass_cnt_d = pass_cnt_q - 8'd1;
            if (pass_cnt_q == 8'd1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end

    bit_d = (state_d == ST_RUN) ? sh_pattern_d[idx_d] : idle_lvl_d;
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_q       <= ST_IDLE;
      idle_lvl_q    <= 1'b0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      pattern_q     <= '0;
      len_m1_q      <= '0;
      repeat_q      <= '0;
      prescale_q    <= PRESCALE_W'(RESET_PRESCALE);
      sh_pattern_q  <= '0;
      sh_len_m1_q   <= '0;
      sh_prescale_q <= '0;
      pre_cnt_q     <= '0;
      pass_cnt_q    <= '0;
      idx_q         <= '0;
      bit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_lvl_q    <= idle_lvl_d;
      irq_en_q      <= irq_en_d;
      done_q        <= done_d;
      pattern_q     <= pattern_d;
      len_m1_q      <= len_m1_d;
      repeat_q      <= repeat_d;
      prescale_q    <= prescale_d;
      sh_pattern_q  <= sh_pattern_d;
      sh_len_m1_q   <= sh_len_m1_d;
      sh_prescale_q <= sh_prescale_d;
      pre_cnt_q     <= pre_cnt_d;
      pass_cnt_q    <= pass_cnt_d;
      idx_q         <= idx_d;
      bit_q         <= bit_d;
    end
  end

  always_comb begin
    avs_s1_readdata = '0;
    if (avs_s1_read) begin
      case (avs_s1_address)
        2'd0: begin
          avs_s1_readdata[0]    = (state_q == ST_RUN);
          avs_s1_readdata[1]    = done_q;
          avs_s1_readdata[2]    = idle_lvl_q;
          avs_s1_readdata[4]    = irq_en_q;
          avs_s1_readdata[12:8] = idx_q;
        end
        2'd1: avs_s1_readdata = pattern_q;
        2'd2: begin
          avs_s1_readdata[4:0]  = len_m1_q;
          avs_s1_readdata[15:8] = repeat_q;
        end
        default: avs_s1_readdata[PRESCALE_W-1:0] = prescale_q;
      endcase
    end
  end

  assign ins_irq = done_q & irq_en_q;
  assign coe_bit = bit_q;

endmodule

// File: tb/tb_bitout_seq.sv
// Directed bench for bitout_seq: finite/infinite sequences, shadowing, restart,
// START/STOP collision, done/irq handling and asynchronous reset.
module tb_bitout_seq;

  logic        clk;
  logic        rst_n;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        irq;
  logic        coe;

  int ntests = 0;
  int nfail  = 0;

  bitout_seq #(.PRESCALE_W(24), .RESET_PRESCALE(0)) dut (
    .csi_clk          (clk),
    .csi_reset_n      (rst_n),
    .avs_s1_address   (address),
    .avs_s1_read      (read),
    .avs_s1_readdata  (readdata),
    .avs_s1_write     (write),
    .avs_s1_writedata (writedata),
    .ins_irq          (irq),
    .coe_bit          (coe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the next negedge, after the write was captured.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    #1;
    d = readdata;
    read = 1'b0;
  endtask

  task automatic test_reset_init();
    logic [31:0] d;
    rst_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    ntests++; if (coe !== 1'b0) begin nfail++; $display("FAIL reset_coe got %0b want 0", coe); end
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL reset_irq got %0b want 0", irq); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      ntests++; if (d !== 32'h0) begin nfail++; $display("FAIL reset_reg%0d got %h want 0", a, d); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_finite();
    logic [31:0] d;
    logic [5:0]  seq;
    seq = 6'b101101;
    wr(2'd1, 32'h5);
    wr(2'd2, 32'h0202);
    wr(2'd3, 32'd3);
    wr(2'd0, 32'h11);
    for (int n = 0; n < 24; n++) begin
      ntests++;
      if (coe !== seq[n/4]) begin nfail++; $display("FAIL finite_coe n=%0d got %0b want %0b", n, coe, seq[n/4]); end
      if (n == 23) begin
        rd(2'd0, d);
        ntests++; if (d[0] !== 1'b1) begin nfail++; $display("FAIL finite_busy_last got %0b want 1", d[0]); end
      end
      @(negedge clk);
    end
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b10) begin nfail++; $display("FAIL finite_end_done_busy got %b want 10", d[1:0]); end
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL finite_irq got %0b want 1", irq); end
    ntests++; if (coe !== 1'b0) begin nfail++; $display("FAIL finite_idle_coe got %0b want 0", coe); end
  endtask

  task automatic test_infinite_stop();
    logic [31:0] d;
    wr(2'd1, 32'h2);
    wr(2'd2, 32'h0001);
    wr(2'd3, 32'd0);
    wr(2'd0, 32'h05);
    for (int n = 0; n < 40; n++) begin
      if (n < 8) begin
        ntests++;
        if (coe !== 1'(n % 2)) begin nfail++; $display("FAIL inf_coe n=%0d got %0b want %0b", n, coe, 1'(n % 2)); end
      end
      @(negedge clk);
    end
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b01) begin nfail++; $display("FAIL inf_still_busy got %b want 01", d[1:0]); end
    wr(2'd0, 32'h06);
    rd(2'd0, d);
    ntests++; if (coe !== 1'b1) begin nfail++; $display("FAIL stop_coe got %0b want 1", coe); end
    ntests++; if (d[1:0] !== 2'b00) begin nfail++; $display("FAIL stop_done_busy got %b want 00", d[1:0]); end
  endtask

  task automatic test_shadow();
    logic [31:0] d;
    wr(2'd1, 32'h1);
    wr(2'd2, 32'h0103);
    wr(2'd3, 32'd1);
    wr(2'd0, 32'h01);
    ntests++; if (coe !== 1'b1) begin nfail++; $display("FAIL shadow_coe0 got %0b want 1", coe); end
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd3, 32'd9);
    for (int n = 2; n < 8; n++) begin
      ntests++; if (coe !== 1'b0) begin nfail++; $display("FAIL shadow_old_coe n=%0d got %0b want 0", n, coe); end
      @(negedge clk);
    end
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b10) begin nfail++; $display("FAIL shadow_old_dwell got %b want 10", d[1:0]); end
    rd(2'd1, d);
    ntests++; if (d !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL shadow_rb_pattern got %h want ffffffff", d); end
    rd(2'd3, d);
    ntests++; if (d !== 32'd9) begin nfail++; $display("FAIL shadow_rb_prescale got %0d want 9", d); end
    wr(2'd0, 32'h01);
    for (int n = 0; n < 40; n++) begin
      ntests++; if (coe !== 1'b1) begin nfail++; $display("FAIL shadow_new_coe n=%0d got %0b want 1", n, coe); end
      @(negedge clk);
    end
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b10) begin nfail++; $display("FAIL shadow_new_end got %b want 10", d[1:0]); end
  endtask

  task automatic test_restart_collision();
    logic [31:0] d;
    wr(2'd1, 32'hF0);
    wr(2'd2, 32'h0107);
    wr(2'd3, 32'd2);
    wr(2'd0, 32'h01);
    repeat (10) @(negedge clk);
    rd(2'd0, d);
    ntests++; if (d[12:8] !== 5'd3) begin nfail++; $display("FAIL restart_idx_before got %0d want 3", d[12:8]); end
    wr(2'd0, 32'h01);
    rd(2'd0, d);
    ntests++; if (d[12:8] !== 5'd0) begin nfail++; $display("FAIL restart_idx got %0d want 0", d[12:8]); end
    ntests++; if (d[1:0] !== 2'b01) begin nfail++; $display("FAIL restart_done_busy got %b want 01", d[1:0]); end
    ntests++; if (coe !== 1'b0) begin nfail++; $display("FAIL restart_coe got %0b want 0", coe); end
    repeat (23) @(negedge clk);
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b01) begin nfail++; $display("FAIL restart_full_len got %b want 01", d[1:0]); end
    @(negedge clk);
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b10) begin nfail++; $display("FAIL restart_end got %b want 10", d[1:0]); end
    wr(2'd0, 32'h01);
    repeat (2) @(negedge clk);
    wr(2'd0, 32'h03);
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b00) begin nfail++; $display("FAIL collide_run got %b want 00", d[1:0]); end
    wr(2'd0, 32'h03);
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b00) begin nfail++; $display("FAIL collide_idle got %b want 00", d[1:0]); end
  endtask

  task automatic test_done_irq();
    logic [31:0] d;
    wr(2'd1, 32'h1);
    wr(2'd2, 32'h0100);
    wr(2'd3, 32'd0);
    wr(2'd0, 32'h11);
    @(negedge clk);
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL short_irq got %0b want 1", irq); end
    wr(2'd0, 32'h18);
    rd(2'd0, d);
    ntests++; if (d[1] !== 1'b0) begin nfail++; $display("FAIL doneclr_done got %0b want 0", d[1]); end
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL doneclr_irq got %0b want 0", irq); end
    ntests++; if (d[4] !== 1'b1) begin nfail++; $display("FAIL doneclr_irqen got %0b want 1", d[4]); end
    wr(2'd3, 32'd3);
    wr(2'd0, 32'h11);
    repeat (3) @(negedge clk);
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b01) begin nfail++; $display("FAIL coincide_pre got %b want 01", d[1:0]); end
    wr(2'd0, 32'h18);
    rd(2'd0, d);
    ntests++; if (d[1:0] !== 2'b10) begin nfail++; $display("FAIL coincide_done got %b want 10", d[1:0]); end
    ntests++; if (irq !== 1'b1) begin nfail++; $display("FAIL coincide_irq got %0b want 1", irq); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'h001F);
    wr(2'd3, 32'd5);
    wr(2'd0, 32'h15);
    repeat (3) @(negedge clk);
    ntests++; if (coe !== 1'b1) begin nfail++; $display("FAIL midrun_coe got %0b want 1", coe); end
    #2;
    rst_n = 1'b0;
    #1;
    ntests++; if (coe !== 1'b0) begin nfail++; $display("FAIL midrun_reset_coe got %0b want 0", coe); end
    ntests++; if (irq !== 1'b0) begin nfail++; $display("FAIL midrun_reset_irq got %0b want 0", irq); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      ntests++; if (d !== 32'h0) begin nfail++; $display("FAIL midrun_reset_reg%0d got %h want 0", a, d); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ntests++; if (coe !== 1'b0) begin nfail++; $display("FAIL post_reset_coe got %0b want 0", coe); end
  endtask

  initial begin
    test_reset_init();
    test_finite();
    test_infinite_stop();
    test_shadow();
    test_restart_collision();
    test_done_irq();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/bitout_seq.md
Name: bitout_seq

Overview:
- Avalon-MM slave that drives one output pin from a programmed bit pattern. Used for watch buzzer chirps, LED blink codes and colon flashing.
- Software loads a pattern, a length, a repeat count and a per-bit dwell time, then starts the sequence.
- The block shifts the pattern out LSB-first and returns the pin to a programmable idle level when finished. It sets a sticky done flag that can raise an interrupt.

Parameters:
- PRESCALE_W, 24, width of the dwell (prescale) register and counter; max dwell is 2^PRESCALE_W clocks per bit.
- RESET_PRESCALE, 0, reset value of the PRESCALE register.

Ports:
- csi_clk  in  1  system clock
- csi_reset_n  in  1  asynchronous active-low reset
- avs_s1_address  in  2  register select
- avs_s1_read  in  1  read strobe
- avs_s1_readdata  out  32  read data
- avs_s1_write  in  1  write strobe
- avs_s1_writedata  in  32  write data
- ins_irq  out  1  interrupt, level = done & irq_en
- coe_bit  out  1  sequenced output pin

Behaviour:
- Interface: one clock (csi_clk); asynchronous active-low reset (csi_reset_n). Every flop clears on csi_reset_n low, independent of the clock.
- Read timing: readdata is combinational from address (read latency 0, no waitrequest). Unused bits read 0.
- Register map:
  - addr 0 CTRL, write:
    - bit0 START, self-clearing
    - bit1 STOP, self-clearing
    - bit2 IDLE_LVL, stored
    - bit3 DONE_CLR, write-1-to-clear
    - bit4 IRQ_EN, stored
  - addr 0 CTRL, read: bit0 BUSY, bit1 DONE, bit2 IDLE_LVL, bit4 IRQ_EN, bits[12:8] current bit index.
  - addr 1 PATTERN [31:0], R/W.
  - addr 2 LEN, R/W:
    - [4:0] LEN_M1: pattern length minus 1, giving 1..32 bits.
    - [15:8] REPEAT: number of passes; 0 = infinite.
  - addr 3 PRESCALE [PRESCALE_W-1:0], R/W: each bit is held PRESCALE+1 clocks.
- Reset values: all registers 0 except PRESCALE = RESET_PRESCALE; state IDLE; coe_bit = 0; ins_irq = 0; DONE = 0.
- Shadow registers: PATTERN, LEN_M1, REPEAT and PRESCALE are copied into shadow registers on START. Writes while BUSY change only the software-visible copy and take effect at the next START.
- States:
  - IDLE: coe_bit = IDLE_LVL (registered, follows a CTRL write one cycle later).
  - RUN: coe_bit = shadow_pattern[idx].
- IDLE -> RUN on a START write:
  - Next cycle: BUSY = 1, idx = 0, coe_bit = pattern[0].
  - Prescale counter loads 0; pass counter loads REPEAT.
  - DONE is cleared on START.
- Dwell: the prescale counter increments each clock in RUN. When it equals shadow PRESCALE it clears to 0 and the bit advances.
- Bit advance:
  - If idx < LEN_M1: idx increments.
  - Else idx wraps to 0 (end of pass).
- End of pass:
  - REPEAT = 0: loop forever.
  - Otherwise the pass counter decrements. When it reaches 0, go to IDLE on the same edge: coe_bit = IDLE_LVL, DONE = 1, BUSY = 0.
- Total RUN duration for a finite sequence: (LEN_M1+1) × (PRESCALE+1) × REPEAT clocks exactly.
- STOP write in RUN: next cycle IDLE, coe_bit = IDLE_LVL. DONE is not set.
- STOP write in IDLE: no effect.
- START while RUN: restart. Shadows reload, idx = 0, counters reload, no DONE pulse.
- START and STOP in the same write: STOP wins; START is ignored.
- DONE set and DONE_CLR on the same cycle: set wins.
- Interrupt: ins_irq = DONE & IRQ_EN, registered-free (combinational from the two flops).
- Reset mid-sequence: immediate IDLE, coe_bit = 0, all registers return to reset values.
- Reads have no side effects. avs_s1_read is unused except as a qualifier.

Test Plan:
- Reset:
  - Stimulus: assert csi_reset_n = 0 mid-RUN.
  - Response: coe_bit = 0, BUSY = 0, DONE = 0, ins_irq = 0 within the same cycle. Registers read 0, PRESCALE reads RESET_PRESCALE.
- Finite sequence:
  - Stimulus: PATTERN = 0x5, LEN_M1 = 2, REPEAT = 2, PRESCALE = 3, CTRL = 0x11 (START + IRQ_EN).
  - Response: coe_bit = 1,0,1,1,0,1, each held 4 clocks. 24 clocks after BUSY rises: BUSY = 0, DONE = 1, ins_irq = 1, coe_bit = 0.
- Infinite loop and STOP:
  - Stimulus: REPEAT = 0, PATTERN = 0x2, LEN_M1 = 1, PRESCALE = 0, IDLE_LVL = 1, START.
  - Response: coe_bit toggles 0,1,0,1 every clock.
  - Stimulus: STOP write.
  - Response: next cycle coe_bit = 1, BUSY = 0, DONE = 0.
- Shadowing:
  - Stimulus: during RUN, write PATTERN = 0xFFFFFFFF and PRESCALE = 9.
  - Response: the output continues the old pattern and dwell. Readback shows the new values. The next START uses the new values.
- Restart and collision:
  - Stimulus: START mid-pass.
  - Response: idx reads 0 the next cycle, no DONE.
  - Stimulus: CTRL = 0x3 (START + STOP) while RUN.
  - Response: IDLE, BUSY = 0.
  - Stimulus: CTRL = 0x3 while IDLE.
  - Response: stays IDLE.
- DONE / IRQ:
  - Stimulus: DONE = 1, IRQ_EN = 1, then write CTRL = 0x18.
  - Response: DONE = 0, ins_irq = 0, IRQ_EN stays 1.
  - Stimulus: DONE_CLR coinciding with the end of the final pass.
  - Response: DONE = 1.
